// File: rtl/ikaopll_bus_sequencer.sv
// Host-side feeder for the IKAOPLL CPU bus: buffers {addr, data} register
// writes in a FIFO and replays each one as an address phase followed by a
// data phase on CS_n/WR_n/A0/D, with strobe and wait times counted in phiM ticks.
module ikaopll_bus_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned WR_PULSE      = 2,
  parameter int unsigned ADDR_WAIT     = 12,
  parameter int unsigned DATA_WAIT     = 84,
  parameter int unsigned ADDR_CACHE_EN = 0
) (
  input  logic                          i_EMUCLK,
  input  logic                          i_RST_n,
  input  logic                          i_phiM_PCEN_n,
  input  logic                          i_FLUSH,
  input  logic                          i_WR_VALID,
  output logic                          o_WR_READY,
  input  logic [7:0]                    i_WR_ADDR,
  input  logic [7:0]                    i_WR_DATA,
  output logic                          o_CS_n,
  output logic                          o_WR_n,
  output logic                          o_A0,
  output logic [7:0]                    o_D,
  output logic                          o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   o_LEVEL
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned MAXA = (WR_PULSE > ADDR_WAIT) ? WR_PULSE : ADDR_WAIT;
  localparam int unsigned MAXW = (MAXA > DATA_WAIT) ? MAXA : DATA_WAIT;
  localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [CW-1:0] PULSE_LD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] AWAIT_LD = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] DWAIT_LD = CW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_STRB,
    S_ADDR_WAIT,
    S_DATA_SETUP,
    S_DATA_STRB,
    S_DATA_WAIT
  } state_t;

  logic            tick;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_next;
  logic            empty;
  logic            push;
  logic            pop;
  logic            cache_hit;
  logic [7:0]      head_addr;
  logic [7:0]      head_data;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      cur_addr;
  logic [7:0]      cur_data;
  logic [7:0]      cache_addr;
  logic            cache_valid;

  // Handshake, pop decision and next FIFO level.
  // A pop happens from IDLE, or directly on the last DATA_WAIT tick so that
  // back-to-back entries need no separate IDLE tick.
  always_comb begin
    tick       = ~i_phiM_PCEN_n;
    empty      = (level == '0);
    push       = i_WR_VALID && o_WR_READY && !i_FLUSH;
    head_addr  = mem[rptr][15:8];
    head_data  = mem[rptr][7:0];
    pop        = tick && !empty && !i_FLUSH &&
                 ((state == S_IDLE) || ((state == S_DATA_WAIT) && (cnt == '0)));
    cache_hit  = (ADDR_CACHE_EN != 0) && cache_valid && (cache_addr == head_addr);
    level_next = level;
    if (i_FLUSH) begin
      level_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_next = level + LW'(1);
        2'b01:   level_next = level - LW'(1);
        default: level_next = level;
      endcase
    end
    o_BUSY  = (state != S_IDLE) || !empty;
    o_LEVEL = level;
  end

  // FIFO storage; entries are {addr, data}.
  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      mem[wptr] <= {i_WR_ADDR, i_WR_DATA};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      o_WR_READY <= 1'b0;
    end else begin
      if (i_FLUSH) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
      level      <= level_next;
      o_WR_READY <= (level_next < LW'(FIFO_DEPTH));
    end
  end

  // Bus-cycle sequencer; all state, counter and output updates happen on ticks.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      o_CS_n      <= 1'b1;
      o_WR_n      <= 1'b1;
      o_A0        <= 1'b0;
      o_D         <= '0;
      cur_addr    <= '0;
      cur_data    <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
    end else if (tick) begin
      if (pop) begin
        cur_addr <= head_addr;
        cur_data <= head_data;
        if (cache_hit) begin
          state <= S_DATA_SETUP;
          o_A0  <= 1'b1;
          o_D   <= head_data;
        end else begin
          state <= S_ADDR_SETUP;
          o_A0  <= 1'b0;
          o_D   <= head_addr;
        end
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR_SETUP: begin
            o_CS_n <= 1'b0;
            o_WR_n <= 1'b0;
            cnt    <= PULSE_LD;
            state  <= S_ADDR_STRB;
          end
          S_ADDR_STRB: begin
            if (cnt == '0) begin
              o_CS_n      <= 1'b1;
              o_WR_n      <= 1'b1;
              cache_addr  <= cur_addr;
              cache_valid <= 1'b1;
              cnt         <= AWAIT_LD;
              state       <= S_ADDR_WAIT;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_ADDR_WAIT: begin
            if (cnt == '0) begin
              o_A0  <= 1'b1;
              o_D   <= cur_data;
              state <= S_DATA_SETUP;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_DATA_SETUP: begin
            o_CS_n <= 1'b0;
            o_WR_n <= 1'b0;
            cnt    <= PULSE_LD;
            state  <= S_DATA_STRB;
          end
          S_DATA_STRB: begin
            if (cnt == '0) begin
              o_CS_n <= 1'b1;
              o_WR_n <= 1'b1;
              cnt    <= DWAIT_LD;
              state  <= S_DATA_WAIT;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_DATA_WAIT: begin
            if (cnt == '0) begin
              state <= S_IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_bus_sequencer.sv
// Directed bench for ikaopll_bus_sequencer: a default instance and an
// address-cache instance, bus strobes captured by negedge monitors.
module tb_ikaopll_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pcen_n = 1'b1;
  logic       flush;
  logic       valid;
  logic       valid_c;
  logic [7:0] addr;
  logic [7:0] data;

  logic       ready, cs_n, wr_n, a0, busy;
  logic [7:0] d;
  logic [4:0] level;
  logic       ready_c, cs_n_c, wr_n_c, a0_c, busy_c;
  logic [7:0] d_c;
  logic [4:0] level_c;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mode  = 0;   // 0: tick every clock, 1: tick 1 in 4, 2: no ticks

  int         fall_cyc[$];
  int         rise_cyc[$];
  logic [8:0] fall_ad[$];
  int         fall_cyc_c[$];
  int         rise_cyc_c[$];
  logic [8:0] fall_ad_c[$];
  int         split_err = 0, stab_err = 0, split_err_c = 0, stab_err_c = 0;
  logic       prev_cs = 1'b1, prev_cs_c = 1'b1;
  logic [8:0] prev_ad = '0, prev_ad_c = '0;

  ikaopll_bus_sequencer #(
    .FIFO_DEPTH(16), .WR_PULSE(2), .ADDR_WAIT(12), .DATA_WAIT(84), .ADDR_CACHE_EN(0)
  ) dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n), .i_FLUSH(flush),
    .i_WR_VALID(valid), .o_WR_READY(ready), .i_WR_ADDR(addr), .i_WR_DATA(data),
    .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0), .o_D(d), .o_BUSY(busy), .o_LEVEL(level)
  );

  ikaopll_bus_sequencer #(
    .FIFO_DEPTH(16), .WR_PULSE(2), .ADDR_WAIT(12), .DATA_WAIT(84), .ADDR_CACHE_EN(1)
  ) dut_c (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n), .i_FLUSH(flush),
    .i_WR_VALID(valid_c), .o_WR_READY(ready_c), .i_WR_ADDR(addr), .i_WR_DATA(data),
    .o_CS_n(cs_n_c), .o_WR_n(wr_n_c), .o_A0(a0_c), .o_D(d_c), .o_BUSY(busy_c), .o_LEVEL(level_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // tick enable generator, changes on the falling edge
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      pcen_n = (mode == 0) ? 1'b0 : (mode == 1) ? (ph != 0) : 1'b1;
    end
  end

  // strobe monitor, default instance
  always @(negedge clk) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      fall_cyc.push_back(cyc);
      fall_ad.push_back({a0, d});
    end
    if (prev_cs === 1'b0 && cs_n === 1'b1) rise_cyc.push_back(cyc);
    if (cs_n !== wr_n) split_err <= split_err + 1;
    if (prev_cs === 1'b0 && cs_n === 1'b0 && {a0, d} !== prev_ad) stab_err <= stab_err + 1;
    prev_cs <= cs_n;
    prev_ad <= {a0, d};
  end

  // strobe monitor, cache instance
  always @(negedge clk) begin
    if (prev_cs_c === 1'b1 && cs_n_c === 1'b0) begin
      fall_cyc_c.push_back(cyc);
      fall_ad_c.push_back({a0_c, d_c});
    end
    if (prev_cs_c === 1'b0 && cs_n_c === 1'b1) rise_cyc_c.push_back(cyc);
    if (cs_n_c !== wr_n_c) split_err_c <= split_err_c + 1;
    if (prev_cs_c === 1'b0 && cs_n_c === 1'b0 && {a0_c, d_c} !== prev_ad_c) stab_err_c <= stab_err_c + 1;
    prev_cs_c <= cs_n_c;
    prev_ad_c <= {a0_c, d_c};
  end

  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic wait_idle(input string tag, input bit sel_c, input int maxc, output int at);
    for (int i = 0; i < maxc; i++) begin
      if ((sel_c ? busy_c : busy) == 1'b0) break;
      step(1);
    end
    if ((sel_c ? busy_c : busy) !== 1'b0) timeout(tag);
    at = cyc;
  endtask

  function automatic int gf(input int k);
    return (k < fall_cyc.size()) ? fall_cyc[k] : -1000;
  endfunction
  function automatic int gr(input int k);
    return (k < rise_cyc.size()) ? rise_cyc[k] : -1000;
  endfunction
  function automatic logic [8:0] ga(input int k);
    return (k < fall_ad.size()) ? fall_ad[k] : 9'h1FF;
  endfunction
  function automatic int gfc(input int k);
    return (k < fall_cyc_c.size()) ? fall_cyc_c[k] : -1000;
  endfunction
  function automatic int grc(input int k);
    return (k < rise_cyc_c.size()) ? rise_cyc_c[k] : -1000;
  endfunction
  function automatic logic [8:0] gac(input int k);
    return (k < fall_ad_c.size()) ? fall_ad_c[k] : 9'h1FF;
  endfunction

  task automatic clear_mon();
    fall_cyc.delete(); rise_cyc.delete(); fall_ad.delete();
    fall_cyc_c.delete(); rise_cyc_c.delete(); fall_ad_c.delete();
  endtask

  initial begin
    int e, t, seen;
    logic [7:0] ea, ed;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; valid_c = 1'b0;
    addr = '0; data = '0; mode = 0;
    step(3);

    // reset state
    check("rst_cs", cs_n, 1'b1);
    check("rst_wr", wr_n, 1'b1);
    check("rst_a0", a0, 1'b0);
    check("rst_d", d, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 5'd0);
    rst_n = 1'b1;
    step(1);
    check("ready_after_release", ready, 1'b1);
    check("ready_c_after_release", ready_c, 1'b1);

    // single full write, tick every clock
    clear_mon();
    valid = 1'b1; addr = 8'h10; data = 8'hAC;
    step(1);
    valid = 1'b0;
    step(1);
    e = cyc;
    check("w1_setup_d", d, 8'h10);
    check("w1_setup_a0", a0, 1'b0);
    check("w1_setup_cs", cs_n, 1'b1);
    wait_idle("w1_idle", 1'b0, 200, t);
    check("w1_total", t - e, 102);
    check("w1_nstrb", fall_cyc.size(), 2);
    check("w1_astrb_start", gf(0) - e, 1);
    check("w1_astrb_len", gr(0) - gf(0), 2);
    check("w1_astrb_ad", ga(0), {1'b0, 8'h10});
    check("w1_gap", gf(1) - gr(0), 13);
    check("w1_dstrb_ad", ga(1), {1'b1, 8'hAC});
    check("w1_dstrb_len", gr(1) - gf(1), 2);

    // tick 1 clock in 4
    clear_mon();
    mode = 1;
    step(2);
    valid = 1'b1; addr = 8'h33; data = 8'h5A;
    step(1);
    valid = 1'b0;
    wait_idle("w2_idle", 1'b0, 700, t);
    check("w2_nstrb", fall_cyc.size(), 2);
    check("w2_astrb_ad", ga(0), {1'b0, 8'h33});
    check("w2_astrb_len", gr(0) - gf(0), 8);
    check("w2_gap", gf(1) - gr(0), 52);
    check("w2_dstrb_ad", ga(1), {1'b1, 8'h5A});
    check("w2_dstrb_len", gr(1) - gf(1), 8);
    check("w2_dwait", t - gr(1), 336);

    // address cache: same register twice
    mode = 0;
    step(2);
    clear_mon();
    valid_c = 1'b1; addr = 8'h20; data = 8'h17;
    step(1);
    data = 8'h07;
    step(1);
    valid_c = 1'b0;
    wait_idle("c_idle", 1'b1, 400, t);
    check("c_nstrb", fall_cyc_c.size(), 3);
    check("c_ad0", gac(0), {1'b0, 8'h20});
    check("c_ad1", gac(1), {1'b1, 8'h17});
    check("c_ad2", gac(2), {1'b1, 8'h07});
    check("c_astrb_len", grc(0) - gfc(0), 2);
    check("c_data_to_data", gfc(2) - grc(1), 85);
    check("c_total", t - (gfc(0) - 1), 189);

    // fill to full with ticks stopped, then drain across the pointer wrap
    mode = 2;
    step(2);
    clear_mon();
    for (int i = 0; i < 16; i++) begin
      addr = 8'h40 + 8'(i); data = 8'hA0 ^ 8'(i); valid = 1'b1;
      step(1);
    end
    check("full_level", level, 5'd16);
    check("full_ready", ready, 1'b0);
    check("full_cs_frozen", cs_n, 1'b1);
    addr = 8'h50; data = 8'h5F;
    step(3);
    check("full_held_level", level, 5'd16);
    mode = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ready) begin
        step(1);
        seen = 1;
        break;
      end
    end
    valid = 1'b0;
    if (seen == 0) timeout("entry17_accept");
    check("entry17_level", level, 5'd16);
    wait_idle("drain_idle", 1'b0, 2500, t);
    check("drain_nstrb", fall_cyc.size(), 34);
    for (int k = 0; k < 17; k++) begin
      ea = (k < 16) ? 8'h40 + 8'(k) : 8'h50;
      ed = (k < 16) ? (8'hA0 ^ 8'(k)) : 8'h5F;
      check($sformatf("drain_addr%0d", k), ga(2 * k), {1'b0, ea});
      check($sformatf("drain_data%0d", k), ga(2 * k + 1), {1'b1, ed});
    end
    check("drain_period", gf(2) - gf(0), 102);

    // reset during the data strobe
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      addr = 8'h60 + 8'(i); data = 8'h90 + 8'(i); valid = 1'b1;
      step(1);
    end
    valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (cs_n == 1'b0 && a0 == 1'b1) begin
        seen = 1;
        break;
      end
      step(1);
    end
    if (seen == 0) timeout("find_dstrb");
    rst_n = 1'b0;
    step(1);
    check("mid_rst_cs", cs_n, 1'b1);
    check("mid_rst_wr", wr_n, 1'b1);
    check("mid_rst_a0", a0, 1'b0);
    check("mid_rst_d", d, 8'h00);
    check("mid_rst_level", level, 5'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    rst_n = 1'b1;
    step(1);
    check("mid_rst_ready_rel", ready, 1'b1);
    step(20);
    check("post_rst_cs", cs_n, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // flush with five entries queued while in ADDR_WAIT
    mode = 2;
    step(2);
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      addr = 8'h70 + 8'(i); data = 8'h30 + 8'(i); valid = 1'b1;
      step(1);
    end
    valid = 1'b0;
    check("fl_level6", level, 5'd6);
    mode = 0;
    seen = 0;
    e = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (cs_n == 1'b0) seen = 1;
      else if (seen == 1 && a0 == 1'b0) begin
        e = 1;
        break;
      end
    end
    if (e == 0) timeout("find_await");
    check("fl_level5", level, 5'd5);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("fl_level0", level, 5'd0);
    check("fl_busy_cont", busy, 1'b1);
    wait_idle("fl_idle", 1'b0, 300, t);
    check("fl_nstrb", fall_cyc.size(), 2);
    check("fl_ad0", ga(0), {1'b0, 8'h70});
    check("fl_ad1", ga(1), {1'b1, 8'h30});
    step(150);
    check("fl_nstrb_after", fall_cyc.size(), 2);
    check("fl_busy_after", busy, 1'b0);
    check("fl_cs_after", cs_n, 1'b1);

    // bus integrity over the whole run
    check("cs_wr_together", split_err, 0);
    check("data_stable_low", stab_err, 0);
    check("cs_wr_together_c", split_err_c, 0);
    check("data_stable_low_c", stab_err_c, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ikaopll_bus_sequencer.md
Name: ikaopll_bus_sequencer

Overview:
- Upstream feeder for the IKAOPLL core CPU-bus port.
- Accepts register writes {reg address, data} from a host through a valid/ready stream and buffers them in a FIFO.
- Replays each write as the chip-legal two-phase bus cycle on CS_n/WR_n/A0/D: an address write, then a data write.
- Enforces the address-to-data and data-to-next-write wait times counted in phiM ticks, so the host never has to time the OPLL bus.

Parameters:
- FIFO_DEPTH, 16: entries buffered; power of two, minimum 2.
- WR_PULSE, 2: phiM ticks that CS_n/WR_n are held low per phase; minimum 1.
- ADDR_WAIT, 12: phiM ticks after the address strobe before the data phase starts.
- DATA_WAIT, 84: phiM ticks after the data strobe before the next write starts.
- ADDR_CACHE_EN, 0: 1 skips the address phase when the register address equals the last address issued.

Ports:
- i_EMUCLK, in, 1: single system clock.
- i_RST_n, in, 1: synchronous active-low reset.
- i_phiM_PCEN_n, in, 1: active-low phiM tick enable; all bus timing advances only on clocks where this is 0.
- i_FLUSH, in, 1: synchronous; empties the FIFO and does not abort the bus cycle in progress.
- i_WR_VALID, in, 1: host write request.
- o_WR_READY, out, 1: FIFO not full.
- i_WR_ADDR, in, 8: OPLL register address.
- i_WR_DATA, in, 8: OPLL register data.
- o_CS_n, out, 1: to IKAOPLL i_CS_n.
- o_WR_n, out, 1: to IKAOPLL i_WR_n.
- o_A0, out, 1: to IKAOPLL i_A0.
- o_D, out, 8: to IKAOPLL i_D.
- o_BUSY, out, 1: FSM not in IDLE, or FIFO non-empty.
- o_LEVEL, out, log2(FIFO_DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (i_RST_n=0 sampled on a clock edge), from any state including mid-cycle:
  - FIFO empty, FSM to IDLE.
  - o_CS_n=1, o_WR_n=1, o_A0=0, o_D=0x00, o_WR_READY=0 during reset, o_BUSY=0, o_LEVEL=0.
  - Address cache marked invalid.
  - The first clock after release has o_WR_READY=1.
- FIFO:
  - Push when i_WR_VALID & o_WR_READY, on any clock regardless of tick.
  - o_WR_READY = (o_LEVEL < FIFO_DEPTH), registered.
  - Push and pop on the same clock leave the level unchanged; a push while full is impossible by the handshake.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Flush: i_FLUSH sets the level and pointers to zero. A push on the same clock as flush is dropped.
- Outputs: all bus outputs are registered and change only on tick clocks.
- FSM (every transition and counter step occurs only on a tick):
  - IDLE: if FIFO non-empty, pop.
    - If ADDR_CACHE_EN and the cache is valid and equal to the popped address, go to DATA_SETUP.
    - Otherwise go to ADDR_SETUP.
  - ADDR_SETUP (1 tick): A0=0, D=addr, CS_n=WR_n=1. Next: ADDR_STRB.
  - ADDR_STRB (WR_PULSE ticks): CS_n=WR_n=0, A0 and D held. Then set the cache to addr, mark it valid, and go to ADDR_WAIT.
  - ADDR_WAIT (ADDR_WAIT ticks): CS_n=WR_n=1, A0/D held. Next: DATA_SETUP.
  - DATA_SETUP (1 tick): A0=1, D=data. Next: DATA_STRB.
  - DATA_STRB (WR_PULSE ticks): CS_n=WR_n=0. Next: DATA_WAIT.
  - DATA_WAIT (DATA_WAIT ticks): CS_n=WR_n=1. Next: IDLE.
- Wait counter: a single down-counter, loaded with (N-1) on state entry; the state exits on the tick where it reads 0. Width covers max(WR_PULSE, ADDR_WAIT, DATA_WAIT).
- Timing with the tick held active every clock:
  - Full write = 1+WR_PULSE+ADDR_WAIT+1+WR_PULSE+DATA_WAIT clocks from IDLE exit. The defaults give 102.
  - A cached write gives 87.
  - Back-to-back FIFO entries have no extra IDLE gap: the IDLE tick that pops the next entry counts as the entry tick.
- CS_n and WR_n always move together. Data never changes while CS_n=0.
- When ticks stop (i_phiM_PCEN_n=1), all outputs freeze.

Test Plan:
- i_phiM_PCEN_n=0, push (0x10,0xAC):
  - Next clock: D=0x10, A0=0.
  - CS_n/WR_n low for exactly 2 clocks.
  - After 12 more clocks: D=0xAC, A0=1, then 2-clock strobe.
  - o_BUSY falls 102 clocks after the pop.
  - The IKAOPLL register 0x10 reads back 0xAC.
- i_phiM_PCEN_n pulsed low 1 clock in 4: every bus interval is measured as 4× the tick count; the address-phase-to-data-phase gap is 13 ticks (strobe end + 12).
- ADDR_CACHE_EN=1, push (0x20,0x17) then (0x20,0x07): the second write has no A0=0 strobe, and its data strobe occurs 84+1 ticks after the first data strobe ends.
- Push 17 entries back-to-back with the tick idle:
  - o_WR_READY drops after the 16th; the 17th is held.
  - o_LEVEL=16.
  - Entries then drain in order; the pointer wrap is exercised by the 17th entry.
- Assert i_RST_n=0 during DATA_STRB: next clock CS_n=WR_n=1, A0=0, D=0, o_LEVEL=0, FSM in IDLE.
- Assert i_FLUSH with 5 queued entries during ADDR_WAIT: the current write completes both phases, then o_BUSY=0 and no further strobes occur.
